// File: rtl/mure_pkg.sv
// Shared types for the trace front end.
// NR_COMMIT_PORTS : number of retirement ports presented to the trace logic
// fifo_entry_s    : one retired instruction as seen by the trace encoder
package mure_pkg;

  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef struct packed {
    logic        valid;
    logic [2:0]  itype;      // 1 = exception
    logic [7:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
    logic [31:0] pc;
    logic        compressed;
  } fifo_entry_s;

endpackage

// File: rtl/commit_sequencer.sv
// Multi-write, single-read commit queue feeding the trace-encoding FSM.
// Serialises up to NR_PORTS commits per cycle into program order (lower port
// first) and presents one entry per cycle; the head is consumed every cycle
// the queue is non-empty.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   enable_i       : 0 = ignore commit inputs (queue keeps draining)
//   flush_i        : synchronous clear, overrides everything else
//   entry_i        : NR_PORTS commit entries, .valid marks a commit
//   fifo_entry_o   : head entry (.valid=1) or all-zero when empty
//   count_o        : occupancy; full_o / empty_o derived from it
//   overflow_o     : sticky, a commit was dropped
//   drop_cnt_o     : saturating count of dropped commits
module commit_sequencer
  import mure_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NR_PORTS = NR_COMMIT_PORTS
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  fifo_entry_s [NR_PORTS-1:0]   entry_i,
  output fifo_entry_s                  fifo_entry_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         overflow_o,
  output logic [7:0]                   drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fifo_entry_s    mem_q [DEPTH];

  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic           deq;
  logic [CW-1:0]  free_space;
  logic [CW-1:0]  n_enq;
  logic [CW-1:0]  n_drop;
  logic [8:0]     drop_sum;
  logic           acc   [NR_PORTS];
  logic [AW-1:0]  waddr [NR_PORTS];

  // The head leaves at every edge while non-empty, so that slot is free for
  // a same-cycle write.
  assign deq        = (count_q != '0);
  assign free_space = CW'(DEPTH) - count_q + CW'(deq);

  // Compaction: each accepted port takes the next slot after those taken by
  // lower-indexed accepted ports; once space runs out the rest are dropped.
  always_comb begin
    n_enq  = '0;
    n_drop = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      acc[p]   = 1'b0;
      waddr[p] = wptr_q + n_enq[AW-1:0];
      if (enable_i && entry_i[p].valid) begin
        if (n_enq < free_space) begin
          acc[p] = 1'b1;
          n_enq  = n_enq + CW'(1);
        end else begin
          n_drop = n_drop + CW'(1);
        end
      end
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 9'(n_drop);
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    overflow_d = overflow_q | (n_drop != '0);
    count_d    = count_q + n_enq - CW'(deq);
    wptr_d     = wptr_q + n_enq[AW-1:0];
    rptr_d     = rptr_q + AW'(deq);
    if (flush_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; it is only observable through a non-zero count.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        if (acc[p]) mem_q[waddr[p]] <= entry_i[p];
      end
    end
  end

  always_comb begin
    fifo_entry_o = '0;
    if (deq) begin
      fifo_entry_o       = mem_q[rptr_q];
      fifo_entry_o.valid = 1'b1;
    end
  end

  assign count_o    = count_q;
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: doc/commit_sequencer.md
COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, 4..64.
REQ-002 SHALL have parameter NR_PORTS, default mure_pkg::NR_COMMIT_PORTS (2), number of commit ports.
REQ-003 SHALL have port clk_i  input  1  clock; single clock domain.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  trace enable; 0 = ignore commit inputs, keep draining.
REQ-006 SHALL have port flush_i  input  1  synchronous queue clear.
REQ-007 SHALL have port entry_i  input  NR_PORTS x mure_pkg::fifo_entry_s  commit-port entries; each entry's .valid marks a commit.
REQ-008 SHALL have port fifo_entry_o  output  mure_pkg::fifo_entry_s  one entry per cycle to the trace-encoding FSM.
REQ-009 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port full_o  output  1  count_o == DEPTH.
REQ-011 SHALL have port empty_o  output  1  count_o == 0.
REQ-012 SHALL have port overflow_o  output  1  sticky: at least one commit was dropped.
REQ-013 SHALL have port drop_cnt_o  output  8  saturating count of dropped commits.

Function
- REQ-014 SHALL serialise up to NR_PORTS commits per cycle into program order: lower port index first.
- REQ-015 SHALL compact enqueues: valid ports occupy consecutive slots from the write pointer; invalid ports consume no slot.
- REQ-016 SHALL read fifo_entry_o combinationally from the head slot with .valid=1 whenever empty_o=0.
- REQ-017 SHALL drive fifo_entry_o all-zero, .valid=0, whenever empty_o=1.
- REQ-018 SHALL dequeue the head at every rising edge with empty_o=0; there is no ready input, and the FSM consumes one entry per cycle.
- REQ-019 SHALL have latency of exactly 1 cycle: an entry written at edge k is visible on fifo_entry_o after edge k when the queue is empty before k.
- REQ-020 SHALL not bypass: an entry arriving while the queue is empty is never output in the same cycle.
- REQ-021 SHALL compute free space as DEPTH - count + (count!=0); the same-cycle dequeue frees a slot.
- REQ-022 SHALL accept valid ports in index order while free space remains.
- REQ-023 SHALL drop the remaining valid ports when free space runs out, set overflow_o, and add the number dropped to drop_cnt_o, saturating at 255.
- REQ-024 SHALL wrap read and write pointers modulo DEPTH; they are $clog2(DEPTH) bits wide and modulo arithmetic is natural.
- REQ-025 SHALL update count by the number enqueued minus the number dequeued (0..NR_PORTS minus 0..1) at each edge.
- REQ-026 SHALL treat all entry_i as invalid while enable_i=0; no enqueue, no drop counting, dequeue continues.
- REQ-027 SHALL, on flush_i=1 at an edge:
  - zero both pointers and count;
  - clear overflow_o and drop_cnt_o;
  - discard same-cycle inputs and the same-cycle head; flush wins over all simultaneous events.
- REQ-028 SHALL preserve each entry's contents bit-exact, including itype, cause, tval, priv, pc and compressed.
- REQ-029 SHALL treat exception entries (itype==1) like any other entry, with no reordering or priority.

Reset
- REQ-030 SHALL, on rst_ni=0 asynchronously: pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, drop_cnt_o=0, fifo_entry_o all-zero.
- REQ-031 SHALL leave storage contents unreset; they are unobservable while empty.
- REQ-032 SHALL, on reset assertion mid-operation, lose all queued entries with no further output until new commits arrive after reset deassertion.

Structure
- REQ-033 SHALL place NR_COMMIT_PORTS and fifo_entry_s in mure_pkg; DEPTH stays a module parameter.
- REQ-034 SHALL be a single module with no sub-module; a multi-write-port queue does not fit a generic FIFO.
- REQ-035 SHALL be instantiated directly ahead of fsm, with fifo_entry_o connected to its fifo_entry_i.

Verification
- REQ-036 SHALL verify: port0 pc=0x100 and port1 pc=0x104 both valid in one cycle -> output pc 0x100 then 0x104 on consecutive cycles, then valid=0.
- REQ-037 SHALL verify: only port1 valid, pc=0x200 -> stored in one slot; count_o=1 for one cycle; output pc 0x200.
- REQ-038 SHALL verify: DEPTH=8, two commits per cycle for 8 cycles -> full_o reached; excess commits dropped; overflow_o=1; drop_cnt_o equals the dropped count; output order has no gaps.
- REQ-039 SHALL verify: count=8 with one commit on port0 -> accepted, since the same-cycle dequeue frees a slot; count stays 8; overflow_o=0.
- REQ-040 SHALL verify: flush_i with count=5 and two simultaneous commits -> count_o=0, empty_o=1, overflow_o=0 next cycle; flushed entries never appear.
- REQ-041 SHALL verify: rst_ni pulsed low mid-burst, asynchronous to the clock -> outputs zero immediately; after release, no stale entry is output.
